// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs
// Definitions shared by the fetch front end of the pipelined MIPS core.
//   CPU_RESET_PC   : default fetch address after reset
//   fetch_state_t  : fetch sequencer states (IDLE, REQ, WAIT)
//   word_align()   : forces an address onto a 4-byte boundary
// ---------------------------------------------------------------------------
package cpu_defs;

    localparam logic [31:0] CPU_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
// Instruction-memory request/ack handshake between the fetch sequencer and
// the instruction memory.
//   imem_req   : request outstanding; address is held until ack
//   imem_addr  : word address of the request
//   imem_ack   : instruction data valid this cycle
//   imem_rdata : instruction word, valid with imem_ack
// Modports: master = fetch sequencer, slave = instruction memory.
// ---------------------------------------------------------------------------
interface fetch_ctrl_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg
// 32-bit program-counter register with load enable.
//   clk    : system clock
//   reset  : asynchronous, active-high; loads RESET_PC
//   load   : when high, pc_in is captured at the rising edge
//   pc_in  : next PC value
//   pc_out : current PC value
// ---------------------------------------------------------------------------
module pc_reg
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = CPU_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_out
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = pc_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_out = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer. Owns the fetch PC, issues one request at a
// time on the instruction-memory handshake, holds the fetched instruction
// in an output buffer (OB) for IF/ID and applies D-stage redirects with
// delay-slot semantics: the instruction in flight or buffered always
// completes, and the redirect lands on the following request.
//   clk, reset     : clock; asynchronous active-high reset
//   stall          : IF/ID held, OB is not consumed
//   redirect_valid : one-cycle branch-taken / jump pulse
//   redirect_pc    : redirect target (low two bits ignored)
//   imem           : instruction-memory handshake (master side)
//   if_valid       : OB holds an instruction
//   if_instr       : buffered instruction
//   if_pc, if_pc4  : address of the buffered instruction, and that + 4
// ---------------------------------------------------------------------------
module fetch_ctrl
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = CPU_RESET_PC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    fetch_ctrl_if.master        imem,
    output logic                if_valid,
    output logic [31:0]         if_instr,
    output logic [31:0]         if_pc,
    output logic [31:0]         if_pc4
);

    fetch_state_t state_q, state_d;

    logic        ob_valid_q, ob_valid_d;
    logic [31:0] ob_instr_q, ob_instr_d;
    logic [31:0] ob_pc_q,    ob_pc_d;

    // Redirect seen while a request is in flight; applied once it completes.
    logic        rb_valid_q, rb_valid_d;
    logic [31:0] rb_pc_q,    rb_pc_d;

    logic        pc_load;
    logic [31:0] pc_next;
    logic [31:0] fetch_pc;
    logic [31:0] redir_aligned;
    logic        ob_consume;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .reset  (reset),
        .load   (pc_load),
        .pc_in  (pc_next),
        .pc_out (fetch_pc)
    );

    assign redir_aligned = word_align(redirect_pc);
    assign ob_consume    = ob_valid_q && !stall;

    always_comb begin
        state_d    = state_q;
        ob_valid_d = ob_valid_q;
        ob_instr_d = ob_instr_q;
        ob_pc_d    = ob_pc_q;
        rb_valid_d = rb_valid_q;
        rb_pc_d    = rb_pc_q;
        pc_load    = 1'b0;
        pc_next    = fetch_pc;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    pc_next = redir_aligned;
                end
            end

            // fetch_pc is the address in flight; OB is empty here.
            REQ: begin
                if (imem.imem_ack) begin
                    ob_valid_d = 1'b1;
                    ob_instr_d = imem.imem_rdata;
                    ob_pc_d    = fetch_pc;
                    state_d    = WAIT;
                    pc_load    = 1'b1;
                    // A redirect arriving with the ack is newer than RB.
                    if (redirect_valid) begin
                        pc_next = redir_aligned;
                    end else if (rb_valid_q) begin
                        pc_next = rb_pc_q;
                    end else begin
                        pc_next = fetch_pc + 32'd4;
                    end
                    rb_valid_d = 1'b0;
                end else if (redirect_valid) begin
                    rb_valid_d = 1'b1;
                    rb_pc_d    = redir_aligned;
                end
            end

            // fetch_pc is the next address, not yet issued.
            WAIT: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    pc_next = redir_aligned;
                end
                if (ob_consume) begin
                    ob_valid_d = 1'b0;
                    state_d    = REQ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ob_valid_q <= 1'b0;
            ob_instr_q <= 32'd0;
            ob_pc_q    <= 32'd0;
            rb_valid_q <= 1'b0;
            rb_pc_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            ob_valid_q <= ob_valid_d;
            ob_instr_q <= ob_instr_d;
            ob_pc_q    <= ob_pc_d;
            rb_valid_q <= rb_valid_d;
            rb_pc_q    <= rb_pc_d;
        end
    end

    // Decoded straight from the state flop so reset drops it without an edge.
    assign imem.imem_req  = (state_q == REQ);
    assign imem.imem_addr = fetch_pc;

    assign if_valid = ob_valid_q;
    assign if_instr = ob_instr_q;
    assign if_pc    = ob_pc_q;
    assign if_pc4   = ob_pc_q + 32'd4;

endmodule
